// File: rtl/video_src_switch.sv
// Frame-synchronous switch: shares one AXI4-Stream video output among NSRC
// pattern sources, enabling only the selected one and switching on frame boundaries.
module video_src_switch #(
   parameter  int DATAW = 32,
   parameter  int NSRC  = 2,
   parameter  int LINES = 1080,
   localparam int SELW  = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [SELW-1:0]       sel_req,
   output logic [NSRC-1:0]       src_en,
   input  logic [NSRC*DATAW-1:0] s_axis_tdata,
   input  logic [NSRC-1:0]       s_axis_tvalid,
   input  logic [NSRC-1:0]       s_axis_tuser,
   input  logic [NSRC-1:0]       s_axis_tlast,
   output logic [NSRC-1:0]       s_axis_tready,
   output logic [DATAW-1:0]      m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic [SELW-1:0]       sel_cur,
   output logic [15:0]           frame_cnt,
   output logic                  sof_err
);

   localparam int LCW = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ENABLE,
      WAIT_SOF,
      PASS,
      DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [SELW-1:0]  sel_cur_q, sel_cur_d;
   logic [LCW-1:0]   line_cnt_q, line_cnt_d;
   logic             mid_line_q, mid_line_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             sof_err_q, sof_err_d;
   logic             drain_idle_q, drain_idle_d;

   logic             sel_ok;
   logic [DATAW-1:0] sel_tdata;
   logic             sel_tvalid, sel_tuser, sel_tlast;
   logic             accept, resync;
   logic [LCW-1:0]   line_base;

   assign sel_ok     = (int'(sel_req) < NSRC);
   assign sel_tdata  = s_axis_tdata[int'(sel_cur_q)*DATAW +: DATAW];
   assign sel_tvalid = s_axis_tvalid[sel_cur_q];
   assign sel_tuser  = s_axis_tuser[sel_cur_q];
   assign sel_tlast  = s_axis_tlast[sel_cur_q];

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      sel_cur_d     = sel_cur_q;
      line_cnt_d    = line_cnt_q;
      mid_line_d    = mid_line_q;
      frame_cnt_d   = frame_cnt_q;
      drain_idle_d  = drain_idle_q;
      sof_err_d     = 1'b0;
      src_en        = '0;
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tuser  = 1'b0;
      m_axis_tlast  = 1'b0;
      accept        = 1'b0;
      resync        = 1'b0;
      line_base     = line_cnt_q;

      case (state_q)
         IDLE: begin
            if (run && sel_ok) begin
               sel_cur_d = sel_req;
               state_d   = ENABLE;
            end
         end
         ENABLE: begin
            src_en[sel_cur_q] = 1'b1;
            if (!run) begin
               state_d      = DRAIN;
               drain_idle_d = 1'b1;
            end else begin
               state_d = WAIT_SOF;
            end
         end
         WAIT_SOF: begin
            // Discard leftover beats; the SOF beat is held for PASS to forward.
            src_en[sel_cur_q]        = 1'b1;
            s_axis_tready[sel_cur_q] = ~sel_tuser;
            if (!run) begin
               state_d      = DRAIN;
               drain_idle_d = 1'b1;
            end else if (sel_tvalid && sel_tuser) begin
               state_d = PASS;
            end
         end
         PASS: begin
            src_en[sel_cur_q]        = 1'b1;
            s_axis_tready[sel_cur_q] = m_axis_tready;
            m_axis_tdata             = sel_tdata;
            m_axis_tvalid            = sel_tvalid;
            m_axis_tuser             = sel_tuser;
            m_axis_tlast             = sel_tlast;
            accept                   = sel_tvalid && m_axis_tready;
            if (accept) begin
               resync    = sel_tuser && ((line_cnt_q != '0) || mid_line_q);
               sof_err_d = resync;
               line_base = resync ? '0 : line_cnt_q;
               if (sel_tlast) begin
                  mid_line_d = 1'b0;
                  if (line_base == LCW'(LINES - 1)) begin
                     line_cnt_d  = '0;
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     if (!run) begin
                        state_d      = DRAIN;
                        drain_idle_d = 1'b1;
                     end else if (sel_ok && (sel_req != sel_cur_q)) begin
                        state_d      = DRAIN;
                        drain_idle_d = 1'b0;
                        sel_cur_d    = sel_req;
                     end
                  end else begin
                     line_cnt_d = line_base + LCW'(1);
                  end
               end else begin
                  mid_line_d = 1'b1;
                  line_cnt_d = line_base;
               end
            end
         end
         DRAIN: begin
            // One cycle with every enable low restarts the sources' pattern counters.
            state_d = drain_idle_q ? IDLE : ENABLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_cur_q    <= '0;
         line_cnt_q   <= '0;
         mid_line_q   <= 1'b0;
         frame_cnt_q  <= '0;
         sof_err_q    <= 1'b0;
         drain_idle_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_cur_q    <= sel_cur_d;
         line_cnt_q   <= line_cnt_d;
         mid_line_q   <= mid_line_d;
         frame_cnt_q  <= frame_cnt_d;
         sof_err_q    <= sof_err_d;
         drain_idle_q <= drain_idle_d;
      end
   end

   assign sel_cur   = sel_cur_q;
   assign frame_cnt = frame_cnt_q;
   assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_video_src_switch.sv
// Directed bench for video_src_switch: behavioural pattern sources (8 px x 4 lines)
// feed the switch; accepted output beats are logged and checked against the pattern.
module tb_video_src_switch;

   localparam int DATAW = 32;
   localparam int NSRC  = 3;
   localparam int LINES = 4;
   localparam int SELW  = $clog2(NSRC);
   localparam int WIDTH = 8;
   localparam int FBEATS = WIDTH * LINES;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  run;
   logic [SELW-1:0]       sel_req;
   logic [NSRC-1:0]       src_en;
   logic [NSRC*DATAW-1:0] s_axis_tdata;
   logic [NSRC-1:0]       s_axis_tvalid;
   logic [NSRC-1:0]       s_axis_tuser;
   logic [NSRC-1:0]       s_axis_tlast;
   logic [NSRC-1:0]       s_axis_tready;
   logic [DATAW-1:0]      m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tuser;
   logic                  m_axis_tlast;
   logic [SELW-1:0]       sel_cur;
   logic [15:0]           frame_cnt;
   logic                  sof_err;

   int vectors     = 0;
   int miscompares = 0;

   video_src_switch #(.DATAW(DATAW), .NSRC(NSRC), .LINES(LINES)) dut (
      .clk(clk), .rst(rst), .run(run), .sel_req(sel_req), .src_en(src_en),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .sel_cur(sel_cur), .frame_cnt(frame_cnt), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DATAW-1:0] pix(input int s, input int y, input int x);
      return {8'(s), 8'(y), 8'(x), 8'h5A};
   endfunction

   // Pattern sources: counters restart whenever en is low; source 1 can inject a stray SOF.
   int sx [NSRC];
   int sy [NSRC];
   bit inject_arm  = 1'b0;
   bit inject_used = 1'b0;
   logic [NSRC-1:0] inj_now;

   initial begin
      for (int i = 0; i < NSRC; i++) begin
         sx[i] = 0;
         sy[i] = 0;
      end
   end

   always_comb begin
      s_axis_tdata  = '0;
      s_axis_tuser  = '0;
      s_axis_tlast  = '0;
      s_axis_tvalid = src_en;
      inj_now       = '0;
      for (int i = 0; i < NSRC; i++) begin
         inj_now[i] = inject_arm && !inject_used && (i == 1) && (sy[i] == 1) && (sx[i] == 3);
         s_axis_tdata[i*DATAW +: DATAW] = pix(i, sy[i], sx[i]);
         s_axis_tuser[i] = ((sx[i] == 0) && (sy[i] == 0)) || inj_now[i];
         s_axis_tlast[i] = (sx[i] == WIDTH - 1);
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (!src_en[i]) begin
            sx[i] <= 0;
            sy[i] <= 0;
         end else if (s_axis_tready[i]) begin
            if (inj_now[i]) begin
               sy[i]       <= 0;
               sx[i]       <= 4;
               inject_used <= 1'b1;
            end else if (sx[i] == WIDTH - 1) begin
               sx[i] <= 0;
               sy[i] <= (sy[i] == LINES - 1) ? 0 : sy[i] + 1;
            end else begin
               sx[i] <= sx[i] + 1;
            end
         end
      end
   end

   // Output log of every accepted beat, plus a count of cycles with sof_err high.
   typedef struct packed {
      logic [DATAW-1:0] data;
      logic             user;
      logic             last;
   } beat_t;

   beat_t q [$];
   int    sof_err_cycles = 0;

   always @(posedge clk) begin
      if (m_axis_tvalid && m_axis_tready)
         q.push_back('{data: m_axis_tdata, user: m_axis_tuser, last: m_axis_tlast});
      if (sof_err)
         sof_err_cycles++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   bit rnd_ready = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready)
         m_axis_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_frame(input logic [15:0] target, input int budget);
      int n = 0;
      while (frame_cnt !== target && n < budget) begin
         step();
         n++;
      end
      check("frame_wait", frame_cnt, target);
   endtask

   task automatic check_frame(input string tag, input int s, input int base);
      int bad = 0;
      check({tag, "_len"}, q.size() - base, FBEATS);
      for (int k = 0; k < FBEATS && base + k < q.size(); k++) begin
         if (q[base+k].data !== pix(s, k / WIDTH, k % WIDTH) ||
             q[base+k].user !== (k == 0) ||
             q[base+k].last !== ((k % WIDTH) == WIDTH - 1))
            bad++;
      end
      check({tag, "_beats"}, bad, 0);
   endtask

   int base;
   int sof_base;
   int nlast;

   initial begin
      rst           = 1'b1;
      run           = 1'b0;
      sel_req       = '0;
      m_axis_tready = 1'b1;
      repeat (3) step();

      check("rst_src_en", src_en, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_sel_cur", sel_cur, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_sof_err", sof_err, 0);

      // First frame from source 0.
      rst = 1'b0;
      run = 1'b1;
      step();
      step();
      check("start_src_en", src_en, 3'b001);
      wait_frame(16'd1, 100);
      check_frame("f1_src0", 0, 0);

      // Mid-frame switch request takes effect only at EOF, via one DRAIN cycle.
      base = q.size();
      repeat (10) step();
      sel_req = 2'd1;
      wait_frame(16'd2, 100);
      check_frame("f2_src0", 0, base);
      check("drain_src_en", src_en, 0);
      check("drain_m_tvalid", m_axis_tvalid, 0);
      check("switch_sel_cur", sel_cur, 1);
      step();
      check("switch_src_en", src_en, 3'b010);
      base = q.size();
      wait_frame(16'd3, 100);
      check_frame("f3_src1", 1, base);

      // Random downstream back-pressure.
      base      = q.size();
      rnd_ready = 1'b1;
      wait_frame(16'd4, 400);
      rnd_ready     = 1'b0;
      m_axis_tready = 1'b1;
      check_frame("f4_stall", 1, base);

      // Out-of-range request at EOF is ignored.
      base    = q.size();
      sel_req = 2'd3;
      wait_frame(16'd5, 100);
      check("oor_sel_cur", sel_cur, 1);
      check("oor_src_en", src_en, 3'b010);
      check("oor_m_tvalid", m_axis_tvalid, 1);
      check_frame("f5_oor", 1, base);
      sel_req = 2'd1;

      // Stray SOF at line 2 beat 3: one sof_err pulse, EOF after 4 more tlasts.
      base       = q.size();
      sof_base   = sof_err_cycles;
      inject_arm = 1'b1;
      wait_frame(16'd6, 100);
      inject_arm = 1'b0;
      check("inj_sof_err", sof_err_cycles - sof_base, 1);
      check("inj_len", q.size() - base, 40);
      nlast = 0;
      for (int k = base; k < q.size(); k++)
         if (q[k].last === 1'b1) nlast++;
      check("inj_tlasts", nlast, 5);
      if (q.size() >= base + 40) begin
         check("inj_beat_user", q[base+11].user, 1);
         check("inj_beat_data", q[base+11].data, pix(1, 1, 3));
         check("inj_next_data", q[base+12].data, pix(1, 0, 4));
         check("inj_eof_last", q[base+39].last, 1);
         check("inj_eof_data", q[base+39].data, pix(1, 3, 7));
      end

      // run=0 mid-frame: frame completes, then everything idles.
      base = q.size();
      repeat (12) step();
      run = 1'b0;
      wait_frame(16'd7, 100);
      check_frame("f7_stop", 1, base);
      check("stop_src_en", src_en, 0);
      check("stop_m_tvalid", m_axis_tvalid, 0);
      repeat (5) step();
      check("idle_src_en", src_en, 0);
      check("idle_s_tready", s_axis_tready, 0);
      check("idle_m_tvalid", m_axis_tvalid, 0);
      check("idle_no_beats", q.size() - base, FBEATS);
      check("idle_frame_cnt", frame_cnt, 7);

      // run dropped during ENABLE: straight back to IDLE, no partial frame.
      base    = q.size();
      sel_req = 2'd0;
      run     = 1'b1;
      step();
      check("abort_enable_en", src_en, 3'b001);
      run = 1'b0;
      step();
      check("abort_drain_en", src_en, 0);
      repeat (3) step();
      check("abort_src_en", src_en, 0);
      check("abort_no_beats", q.size() - base, 0);
      check("abort_frame_cnt", frame_cnt, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
